// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter and related schedulers.
package fifo_arb_pkg;

  localparam int unsigned STAT_CNT_W = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Modulo increment of a round-robin pointer; works for non-power-of-two counts.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 1 >= num_req) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of valid at or after start, wrapping at N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int unsigned pos;

  always_comb begin
    found = 1'b0;
    idx   = start;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(start) + i;
      if (pos >= N) pos = pos - N;
      if (!found && valid[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one sync FIFO write port.
// Optional per-requester packet / total beat counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*STAT_CNT_W-1:0] pkt_cnt,
  output logic [31:0]               beat_cnt,
`endif
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      locked
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] g;
  logic            acc;

  rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr_pick (
    .valid (req_valid),
    .start (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

  // Grant selection, zero-latency beat acceptance and lock/pointer transitions.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    req_ready = '0;
    if (state_q == ARB_LOCKED) begin
      g            = gnt_q;
      acc          = req_valid[gnt_q] & ~fifo_full;
      req_ready[g] = ~fifo_full;
    end else begin
      g            = pick_idx;
      acc          = pick_found & ~fifo_full;
      req_ready[g] = pick_found & ~fifo_full;
    end
    if (acc) begin
      if (req_last[g]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = ID_W'(rr_next(32'(g), NUM_REQ));
      end else if (state_q == ARB_IDLE) begin
        state_d = ARB_LOCKED;
        gnt_d   = g;
      end
    end
  end

  assign fifo_wen  = acc;
  assign fifo_data = req_data[32'(g)*DATA_W +: DATA_W];
  assign grant_id  = g;
  assign locked    = (state_q == ARB_LOCKED);

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else if (acc) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (req_last[g])
        pkt_cnt[32'(g)*STAT_CNT_W +: STAT_CNT_W] <=
          pkt_cnt[32'(g)*STAT_CNT_W +: STAT_CNT_W] + STAT_CNT_W'(1);
    end
  end
`endif

  a_no_wen_when_full: assert property (@(posedge clk) disable iff (rst) !(fifo_wen && fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=32).
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_wen;
  logic [DATA_W-1:0]         fifo_data;
  logic [ID_W-1:0]           grant_id;
  logic                      locked;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     pkt_cnt;
  logic [31:0]               beat_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef FIFO_WR_ARB_STATS_EN
    .pkt_cnt   (pkt_cnt),
    .beat_cnt  (beat_cnt),
`endif
    .fifo_full (fifo_full),
    .fifo_wen  (fifo_wen),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input logic [DATA_W-1:0] d, input logic lst);
    req_data[i*DATA_W +: DATA_W] = d;
    req_last[i] = lst;
  endtask

  // Settle combinational outputs, then compare the full output set for this cycle.
  task automatic expect_cycle(input string tag, input logic wen, input logic [ID_W-1:0] gid,
                              input logic lck, input logic [NUM_REQ-1:0] rdy,
                              input logic [DATA_W-1:0] dat);
    #1;
    chk({tag, "_wen"}, 64'(fifo_wen), 64'(wen));
    chk({tag, "_gid"}, 64'(grant_id), 64'(gid));
    chk({tag, "_locked"}, 64'(locked), 64'(lck));
    chk({tag, "_ready"}, 64'(req_ready), 64'(rdy));
    if (wen) chk({tag, "_data"}, 64'(fifo_data), 64'(dat));
  endtask

  initial begin
    logic [ID_W-1:0] e;
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    expect_cycle("t1_reset", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'h0);
    chk("t1_beat_cnt", 64'(beat_cnt), 64'h0);
`endif
    rst = 1'b0;
    tick();

    // 2: single-beat packets from req 1 and 3 alternate
    set_beat(1, 32'h11, 1'b1);
    set_beat(3, 32'h33, 1'b1);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 2'd1 : 2'd3;
      expect_cycle("t2_rr", 1'b1, e, 1'b0, 4'(1) << e, (e == 2'd1) ? 32'h11 : 32'h33);
      tick();
    end
    req_valid = '0;
    expect_cycle("t2_ptr", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);

    // 3: 3-beat packet from req 0 with req 2 waiting
    set_beat(0, 32'hA0, 1'b0);
    set_beat(2, 32'hC2, 1'b1);
    req_valid = 4'b0101;
    expect_cycle("t3_b0", 1'b1, 2'd0, 1'b0, 4'b0001, 32'hA0);
    tick();
    set_beat(0, 32'hA1, 1'b0);
    expect_cycle("t3_b1", 1'b1, 2'd0, 1'b1, 4'b0001, 32'hA1);
    tick();
    set_beat(0, 32'hA2, 1'b1);
    expect_cycle("t3_b2", 1'b1, 2'd0, 1'b1, 4'b0001, 32'hA2);
    tick();
    req_valid = 4'b0100;
    expect_cycle("t3_req2", 1'b1, 2'd2, 1'b0, 4'b0100, 32'hC2);
    tick();
    req_valid = '0;
    expect_cycle("t3_ptr", 1'b0, 2'd3, 1'b0, 4'b0000, 32'h0);

    // 4: FIFO full on second beat of a locked packet (pointer wraps 3 -> 0 -> 1)
    set_beat(1, 32'hB0, 1'b0);
    req_valid = 4'b0010;
    expect_cycle("t4_b0", 1'b1, 2'd1, 1'b0, 4'b0010, 32'hB0);
    tick();
    set_beat(0, 32'hD0, 1'b1);
    set_beat(1, 32'hB1, 1'b1);
    req_valid = 4'b0011;
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_cycle("t4_full", 1'b0, 2'd1, 1'b1, 4'b0000, 32'h0);
      tick();
    end
    fifo_full = 1'b0;
    expect_cycle("t4_resume", 1'b1, 2'd1, 1'b1, 4'b0010, 32'hB1);
    tick();
    req_valid = '0;
    expect_cycle("t4_ptr", 1'b0, 2'd2, 1'b0, 4'b0000, 32'h0);

    // 5: valid drops mid-packet, grant held and req 0 ignored
    set_beat(2, 32'hE0, 1'b0);
    req_valid = 4'b0101;
    expect_cycle("t5_b0", 1'b1, 2'd2, 1'b0, 4'b0100, 32'hE0);
    tick();
    req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      expect_cycle("t5_drop", 1'b0, 2'd2, 1'b1, 4'b0100, 32'h0);
      tick();
    end
    set_beat(2, 32'hE1, 1'b0);
    req_valid = 4'b0101;
    expect_cycle("t5_b1", 1'b1, 2'd2, 1'b1, 4'b0100, 32'hE1);
    tick();

    // 6: reset while locked on req 2
    req_valid = '0;
    rst = 1'b1;
    expect_cycle("t6_in_rst", 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("t6_pkt_clr", 64'(pkt_cnt), 64'h0);
    chk("t6_beat_clr", 64'(beat_cnt), 64'h0);
`endif
    tick();
    rst = 1'b0;
    set_beat(0, 32'hF0, 1'b1);
    set_beat(3, 32'hF3, 1'b1);
    req_valid = 4'b1001;
    expect_cycle("t6_win", 1'b1, 2'd0, 1'b0, 4'b0001, 32'hF0);
    tick();
    set_beat(1, 32'h51, 1'b1);
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      expect_cycle("t6_req1", 1'b1, 2'd1, 1'b0, 4'b0010, 32'h51);
      tick();
    end
    req_valid = '0;
    expect_cycle("t6_ptr", 1'b0, 2'd2, 1'b0, 4'b0000, 32'h0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("t6_pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd1);
    chk("t6_pkt_cnt1", 64'(pkt_cnt[31:16]), 64'd3);
    chk("t6_pkt_cnt23", 64'(pkt_cnt[63:32]), 64'd0);
    chk("t6_beat_cnt", 64'(beat_cnt), 64'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-aware write arbiter that shares one synchronous FIFO write port between NUM_REQ requesters.
- Each requester presents a valid/ready/last stream. The arbiter grants one requester at a time and holds the grant until that requester's packet ends (last beat accepted).
- It drives the FIFO's wen/data_in and obeys the FIFO's full flag. It sits directly in front of the team's sync FIFO.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 32, width of one data beat; equals the FIFO element width.
- ID_W, $clog2(NUM_REQ), local, width of grant index.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet; meaningful only with valid
- req_data  in  NUM_REQ*DATA_W  packed beats; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle (with valid)
- fifo_full  in  1  FIFO full flag
- fifo_wen  out  1  FIFO write enable
- fifo_data  out  DATA_W  FIFO write data
- grant_id  out  ID_W  index of current or selected grantee
- locked  out  1  packet in progress; grant is held

Behaviour:
- State: LOCK register (IDLE/LOCKED), rr_ptr[ID_W], gnt_q[ID_W]. All are reset asynchronously by rst: IDLE, rr_ptr=0, gnt_q=0.
- Grant select in IDLE (combinational):
  - First requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ. Wrap is a modulo compare against NUM_REQ, not power-of-2 overflow.
  - If no requester is valid: grant_id=rr_ptr and nothing is accepted.
- Grant in LOCKED: grant_id=gnt_q. Other requesters' valid is ignored.
- Beat acceptance (combinational, zero latency): acc = req_valid[g] & ~fifo_full.
  - fifo_wen=acc.
  - fifo_data=req_data slice g.
  - req_ready[g]=~fifo_full; req_ready of all other requesters is 0.
  - No cycle of bubble exists between the arbitration decision and the first write.
- Transitions:
  - IDLE, acc & ~last: go to LOCKED and set gnt_q=g.
  - IDLE, acc & last (single-beat packet): stay IDLE and set rr_ptr=g+1 mod NUM_REQ.
  - LOCKED, acc & last: go to IDLE and set rr_ptr=gnt_q+1 mod NUM_REQ.
  - LOCKED, no acc (valid low or FIFO full): hold.
- The rr_ptr update happens only at packet end, so fairness is per packet, not per beat.
- Reset outputs: fifo_wen=0, req_ready=0, locked=0, grant_id=0.
- fifo_full=1 blocks every write. The grant is kept, the state does not advance and no data is lost.
- Valid may drop mid-packet in LOCKED: hold the grant and do not move the pointer.
- rst asserted mid-packet: return to IDLE immediately and discard the partial-packet lock. The FIFO contents are the owner's concern.
- Never assert fifo_wen while fifo_full=1 (checked by assertion).
- locked = (state==LOCKED).

Optional Feature:
- FIFO_WR_ARB_STATS_EN defined:
  - Adds output pkt_cnt (NUM_REQ*16): per-requester count of accepted last beats.
  - Each count is 16-bit, wraps at 0xFFFF to 0, and resets to 0 on rst.
  - Adds output beat_cnt (32): total accepted beats, wrapping.
- Not defined: both ports and all counter logic are absent.

Decomposition:
- Package fifo_arb_pkg:
  - typedef arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - Function rr_next(ptr, NUM_REQ) for the modulo increment.
  - Constant STAT_CNT_W=16.
- Sub-module rr_pick:
  - Combinational round-robin priority search: valid vector + start pointer gives found flag + index.
  - Reused by future read-side schedulers.

Test Plan:
1. Reset, all valid=0 → fifo_wen=0, grant_id=0, locked=0, req_ready=0.
2. NUM_REQ=4; req 1 and 3 each send one single-beat packet, continuously valid → writes alternate 1,3,1,3; after each write rr_ptr moves to winner+1.
3. Req 0 sends a 3-beat packet (data 0xA0, 0xA1, 0xA2) while req 2 is valid throughout → FIFO receives A0, A1, A2, then req 2's beat. locked=1 for beats 1–2 and 0 after the last beat.
4. fifo_full=1 for 5 cycles on the second beat of a locked packet → fifo_wen=0 and req_ready=0 for those cycles, grant held; resumes with the same beat once full=0.
5. Mid-packet valid drop for 2 cycles → no write, grant and lock held, no other requester granted.
6. rst pulsed while LOCKED on req 2 → next cycle IDLE, rr_ptr=0, req 0 wins if valid. With FIFO_WR_ARB_STATS_EN, pkt_cnt is cleared and counts 3 after three last beats from req 1.
